sm3_msg_expand: RTL and testbench
=================================

// Module: sm3_msg_expand
// PURPOSE
// - Message-expansion feeder for the SM3 compression iterator: the transmit end of its {W, W'} beat stream.
// - Accepts one padded 512-bit message block and emits 64 consecutive beats data_iter = {W_j, W'_j}, j=0..63, with data_iter_en.
// - Guarantees data_iter_en deasserts between blocks, so the downstream rising-edge detector re-initialises state per block.
// PARAMETERS
// - WORD_WIDTH  32  word width; SM3 fixes 32, other values unsupported
// - ROUNDS      64  beats per block; SM3 fixes 64
// - GAP_CYCLES  1   idle cycles (data_iter_en=0) forced after each block; legal range 1..15
// PORTS
// - clk         in   1                 clock, rising edge
// - rst_n       in   1                 reset, asynchronous, active-low
// - blk         in   16*WORD_WIDTH     padded block; word 0 = blk[511:480] (W_0), word 15 = blk[31:0]
// - blk_valid   in   1                 block presented
// - blk_ready   out  1                 block accepted when blk_valid & blk_ready on a clk edge
// - data_iter   out  2*WORD_WIDTH      {W_j[63:32], W'_j[31:0]}
// - data_iter_en out 1                 beat valid; high for exactly ROUNDS consecutive cycles per block
// - data_last   out  1                 high together with beat j=63 only
// - busy        out  1                 high in RUN and GAP
// BEHAVIOUR
// - Reset (async): state=IDLE; blk_ready=0 during reset, 1 from first edge after release; data_iter=0; data_iter_en=0; data_last=0; busy=0; window and counter=0.
// - FSM IDLE -> RUN on handshake; RUN -> GAP when j=63 beat issued; GAP -> IDLE after GAP_CYCLES cycles. blk_ready=1 only in IDLE.
// - Latency: handshake at edge t -> beat j=0 registered and visible after edge t, i.e. data_iter_en high for cycles t+1..t+64; low for >=GAP_CYCLES cycles after.
// - No backpressure: downstream has no ready; beats are never stalled once RUN starts.
// - Datapath: 16-word sliding window win[0..15] = W_j..W_{j+15}, loaded from blk on handshake.
//   - Beat output: W_j = win[0]; W'_j = win[0] ^ win[4]. All outputs registered.
//   - Each RUN cycle: shift window down one word; win[15] <= W_{j+16} =
//     P1(win[0] ^ win[7] ^ (win[13]<<<15)) ^ (win[3]<<<7) ^ win[10], P1(x) = x ^ (x<<<15) ^ (x<<<23).
//   - All arithmetic is XOR/rotate mod 2^32; no carries. Words j>=64 computed but never emitted.
// - Round counter 6 bits, 0..63, no wrap within a block; cleared on entering RUN.
// - blk_valid while busy: ignored, blk not sampled; upstream must hold blk_valid until accepted.
// - blk_valid high continuously: blocks accepted back-to-back separated by exactly GAP_CYCLES+1 idle cycles of data_iter_en (GAP plus IDLE handshake cycle).
// - Reset mid-RUN: outputs return to reset values immediately; partial block discarded, no further beats.
// CONFIGURATION
// - Macro SM3_BSWAP_EN:
//   - defined: each 32-bit word of blk byte-reversed at load (little-endian byte stream input).
//   - undefined: blk words loaded as-is (big-endian, SM3 standard order).
//   - Timing, FSM and all other ports identical in both builds.
// TESTING
// - Reset: hold rst_n=0 with blk_valid=1 -> data_iter_en=0, busy=0, no handshake; release -> blk_ready=1 next edge.
// - "abc" block (blk=0x61626380, 14 zero words, 0x00000018): beat0 = {61626380, 61626380}; W_16 emitted as beat16 high word = 9092e200; exactly 64 beats, data_last on beat 63 only.
// - Back-to-back: two blocks with blk_valid held high, GAP_CYCLES=1 -> data_iter_en low for exactly 2 cycles between bursts; second burst's beat0 matches block 2 word 0.
// - Busy ignore: toggle blk_valid/blk with new data during RUN -> current beats unchanged, new block accepted only after IDLE reached.
// - Mid-run reset: assert rst_n=0 at beat 30 -> data_iter_en=0 same cycle; after release, fresh block yields correct beat0 and 64 beats.
// - SM3_BSWAP_EN build: feed "abc" block byte-swapped per word (0x80636261...) -> beats identical to undefined-build "abc" run.

Source files
------------

// File: rtl/sm3_msg_expand.sv
// SM3 message-expansion feeder: takes one padded 512-bit block and streams the 64 {W_j, W'_j} beats.
// Build option SM3_BSWAP_EN: byte-reverse each input word at load (little-endian byte stream input).
module sm3_msg_expand #(
   parameter int WORD_WIDTH = 32,
   parameter int ROUNDS     = 64,
   parameter int GAP_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [16*WORD_WIDTH-1:0] blk,
   input  logic                    blk_valid,
   output logic                    blk_ready,
   output logic [2*WORD_WIDTH-1:0] data_iter,
   output logic                    data_iter_en,
   output logic                    data_last,
   output logic                    busy
);

   localparam int CW = $clog2(ROUNDS);
   localparam int GW = 4;
   localparam logic [CW-1:0] CNT_LAST = CW'(ROUNDS - 1);
   localparam logic [CW-1:0] CNT_PEN  = CW'(ROUNDS - 2);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   state_t                  r_state;
   state_t                  w_nextState;
   logic                    r_ready;
   logic                    r_busy;
   logic                    r_en;
   logic                    r_last;
   logic [2*WORD_WIDTH-1:0] r_dataIter;
   logic [CW-1:0]           r_cnt;
   logic [GW-1:0]           r_gapCnt;
   logic [WORD_WIDTH-1:0]   r_win  [16];
   logic [WORD_WIDTH-1:0]   w_load [16];
   logic [WORD_WIDTH-1:0]   w_newWord;
   logic                    w_accept;

   function automatic logic [WORD_WIDTH-1:0] rotl(input logic [WORD_WIDTH-1:0] x, input int n);
      return (x << n) | (x >> (WORD_WIDTH - n));
   endfunction

   function automatic logic [WORD_WIDTH-1:0] p1(input logic [WORD_WIDTH-1:0] x);
      return x ^ rotl(x, 15) ^ rotl(x, 23);
   endfunction

   function automatic logic [WORD_WIDTH-1:0] bswap(input logic [WORD_WIDTH-1:0] x);
      logic [WORD_WIDTH-1:0] y;
      y = '0;
      for (int b = 0; b < WORD_WIDTH/8; b++) begin
         y[b*8 +: 8] = x[WORD_WIDTH-8-b*8 +: 8];
      end
      return y;
   endfunction

   // Word 0 sits in the most significant slice of blk.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
`ifdef SM3_BSWAP_EN
         w_load[i] = bswap(blk[(15-i)*WORD_WIDTH +: WORD_WIDTH]);
`else
         w_load[i] = blk[(15-i)*WORD_WIDTH +: WORD_WIDTH];
`endif
      end
   end

   assign w_accept  = blk_valid & r_ready;
   assign w_newWord = p1(r_win[0] ^ r_win[7] ^ rotl(r_win[13], 15)) ^ rotl(r_win[3], 7) ^ r_win[10];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = RUN;
         RUN:     if (r_cnt == CNT_LAST) w_nextState = GAP;
         GAP:     if (r_gapCnt == GAP_LAST) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // The window always holds W_j..W_{j+15} for the beat currently on data_iter, so the next
   // beat comes from r_win[1]/r_win[5] while the window shifts in W_{j+16}.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_en       <= 1'b0;
         r_last     <= 1'b0;
         r_dataIter <= '0;
         r_cnt      <= '0;
         r_gapCnt   <= '0;
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
      end else begin
         r_ready <= (w_nextState == IDLE);
         r_busy  <= (w_nextState != IDLE);
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  for (int i = 0; i < 16; i++) r_win[i] <= w_load[i];
                  r_dataIter <= {w_load[0], w_load[0] ^ w_load[4]};
                  r_en       <= 1'b1;
                  r_last     <= 1'b0;
                  r_cnt      <= '0;
               end
            end
            RUN: begin
               if (r_cnt == CNT_LAST) begin
                  r_en       <= 1'b0;
                  r_last     <= 1'b0;
                  r_dataIter <= '0;
                  r_gapCnt   <= '0;
               end else begin
                  for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                  r_win[15]  <= w_newWord;
                  r_dataIter <= {r_win[1], r_win[1] ^ r_win[5]};
                  r_last     <= (r_cnt == CNT_PEN);
                  r_cnt      <= r_cnt + 1'b1;
               end
            end
            GAP: begin
               r_gapCnt <= r_gapCnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign blk_ready    = r_ready;
   assign busy         = r_busy;
   assign data_iter    = r_dataIter;
   assign data_iter_en = r_en;
   assign data_last    = r_last;

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Self-checking bench for sm3_msg_expand: known "abc" vectors plus random blocks against a word-array model.
// Builds with or without SM3_BSWAP_EN; the bench byte-swaps its stimulus to match.
module tb_sm3_msg_expand;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [511:0] blk = '0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic [63:0]  data_iter;
   logic         data_iter_en;
   logic         data_last;
   logic         busy;

   int total = 0;
   int bad   = 0;

   logic [31:0] mW [68];
   logic [63:0] capBeats [64];
   int          capN, capLastPos, capLastCnt, capReadyHi;

   typedef struct {
      string       name;
      int          idx;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [6];

   localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

   sm3_msg_expand dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .blk          (blk),
      .blk_valid    (blk_valid),
      .blk_ready    (blk_ready),
      .data_iter    (data_iter),
      .data_iter_en (data_iter_en),
      .data_last    (data_last),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Reference: full W[0..67] array from the SM3 expansion recurrence.
   function automatic void modelExpand(input logic [511:0] b);
      logic [31:0] t;
      for (int j = 0; j < 16; j++) mW[j] = b[511-32*j -: 32];
      for (int j = 16; j < 68; j++) begin
         t = mW[j-16] ^ mW[j-9] ^ rol(mW[j-3], 15);
         mW[j] = (t ^ rol(t, 15) ^ rol(t, 23)) ^ rol(mW[j-13], 7) ^ mW[j-6];
      end
   endfunction

   function automatic logic [63:0] expBeat(input int j);
      return {mW[j], mW[j] ^ mW[j+4]};
   endfunction

   function automatic logic [511:0] toDut(input logic [511:0] b);
      logic [511:0] r;
      r = b;
`ifdef SM3_BSWAP_EN
      for (int w = 0; w < 16; w++)
         for (int k = 0; k < 4; k++)
            r[w*32 + k*8 +: 8] = b[w*32 + (3-k)*8 +: 8];
`endif
      return r;
   endfunction

   function automatic logic [511:0] randBlock();
      logic [511:0] r;
      for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Record the burst starting at the current sample point until data_iter_en drops.
   task automatic captureBurst(input bit jitter, input logic [511:0] other);
      capN = 0; capLastPos = -1; capLastCnt = 0; capReadyHi = 0;
      for (int k = 0; k < 80; k++) begin
         if (!data_iter_en) break;
         if (capN < 64) capBeats[capN] = data_iter;
         if (data_last) begin capLastPos = capN; capLastCnt++; end
         if (blk_ready) capReadyHi++;
         capN++;
         if (jitter) begin
            blk_valid = 1'($urandom_range(0, 1));
            blk = ($urandom_range(0, 1) != 0) ? toDut(other) : randBlock();
         end
         step();
      end
   endtask

   task automatic waitReady(input string tag, output bit got);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (blk_ready) begin got = 1'b1; break; end
         step();
      end
      if (!got) checkInt({tag, " handshake timeout"}, 0, 1);
   endtask

   task automatic applyStimulus(input string tag, input logic [511:0] b, input bit jitter, input logic [511:0] other);
      bit got;
      blk = toDut(b);
      blk_valid = 1'b1;
      waitReady(tag, got);
      step();
      blk_valid = 1'b0;
      captureBurst(jitter, other);
   endtask

   task automatic checkOutput(input string tag, input logic [511:0] b);
      modelExpand(b);
      checkInt({tag, " beat count"}, capN, 64);
      checkInt({tag, " last position"}, capLastPos, 63);
      checkInt({tag, " last count"}, capLastCnt, 1);
      checkInt({tag, " ready during run"}, capReadyHi, 0);
      for (int j = 0; j < 64 && j < capN; j++)
         checkVal($sformatf("%s beat%0d", tag, j), capBeats[j], expBeat(j));
   endtask

   task automatic countLow(output int lows);
      lows = 0;
      for (int k = 0; k < 20; k++) begin
         if (data_iter_en) break;
         lows++;
         step();
      end
   endtask

   initial begin
      logic [511:0] b1, b2;
      int           n1, lows;
      bit           got;

      vecs[0] = '{"abc beat0",  0,  {32'h61626380, 32'h61626380}};
      vecs[1] = '{"abc beat3",  3,  {32'h00000000, 32'h00000000}};
      vecs[2] = '{"abc beat11", 11, {32'h00000000, 32'h00000018}};
      vecs[3] = '{"abc beat12", 12, {32'h00000000, 32'h9092e200}};
      vecs[4] = '{"abc beat13", 13, {32'h00000000, 32'h00000000}};
      vecs[5] = '{"abc beat16", 16, {32'h9092e200, 32'h9092e200}};

      // Reset held with a block offered: nothing may start.
      blk = toDut(ABC);
      blk_valid = 1'b1;
      repeat (3) step();
      checkInt("reset en", int'(data_iter_en), 0);
      checkInt("reset busy", int'(busy), 0);
      checkInt("reset ready", int'(blk_ready), 0);
      checkVal("reset data", data_iter, 64'h0);
      rst_n = 1'b1;
      step();
      checkInt("ready after release", int'(blk_ready), 1);
      checkInt("no start after release", int'(data_iter_en), 0);
      blk_valid = 1'b0;
      step();

      // Known "abc" block against table and model.
      applyStimulus("abc", ABC, 1'b0, '0);
      for (int i = 0; i < 6; i++) checkVal(vecs[i].name, capBeats[vecs[i].idx], vecs[i].exp);
      checkOutput("abc", ABC);

      // Back-to-back blocks with blk_valid held high.
      b1 = randBlock();
      b2 = randBlock();
      blk = toDut(b1);
      blk_valid = 1'b1;
      waitReady("b2b", got);
      step();
      blk = toDut(b2);
      n1 = 0;
      for (int k = 0; k < 80; k++) begin
         if (!data_iter_en) break;
         n1++;
         step();
      end
      checkInt("b2b burst1 length", n1, 64);
      countLow(lows);
      checkInt("b2b gap", lows, 2);
      blk_valid = 1'b0;
      modelExpand(b2);
      checkVal("b2b block2 beat0", data_iter, expBeat(0));
      captureBurst(1'b0, '0);
      checkOutput("b2b block2", b2);

      // Busy ignore: jitter valid/blk during the run, then offer a new block.
      b1 = randBlock();
      b2 = randBlock();
      applyStimulus("busy", b1, 1'b1, b2);
      checkOutput("busy blockA", b1);
      blk = toDut(b2);
      blk_valid = 1'b1;
      countLow(lows);
      checkInt("busy gap", lows, 2);
      blk_valid = 1'b0;
      captureBurst(1'b0, '0);
      checkOutput("busy blockB", b2);

      // Reset in the middle of a run.
      b1 = randBlock();
      blk = toDut(b1);
      blk_valid = 1'b1;
      waitReady("midrst", got);
      step();
      blk_valid = 1'b0;
      modelExpand(b1);
      repeat (30) step();
      checkVal("midrst beat30", data_iter, expBeat(30));
      rst_n = 1'b0;
      #1;
      checkInt("midrst en", int'(data_iter_en), 0);
      checkInt("midrst busy", int'(busy), 0);
      checkInt("midrst ready", int'(blk_ready), 0);
      checkVal("midrst data", data_iter, 64'h0);
      blk_valid = 1'b1;
      step();
      step();
      checkInt("midrst held en", int'(data_iter_en), 0);
      rst_n = 1'b1;
      blk_valid = 1'b0;
      step();
      checkInt("midrst ready after release", int'(blk_ready), 1);
      b2 = randBlock();
      applyStimulus("midrst fresh", b2, 1'b0, '0);
      checkOutput("midrst fresh", b2);

      // Random blocks.
      for (int r = 0; r < 3; r++) begin
         b1 = randBlock();
         applyStimulus($sformatf("rand%0d", r), b1, 1'b0, '0);
         checkOutput($sformatf("rand%0d", r), b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
